// File: rtl/program_counter.sv
// program_counter: architectural fetch PC register for the RV32 pipeline.
// The next-PC value (PC+4 or a branch target) is chosen upstream; this block
// registers it on enabled edges, keeps the PC word-aligned by clearing the two
// low bits, and raises a one-cycle flag when the requested address was not
// word-aligned.
//
// Interface contract: there is no valid/ready handshake. 'en' is a pure load
// enable, sampled on the rising edge: en=1 loads pc_in, en=0 holds the PC
// (stall). pc_in is ignored entirely while en=0, so X/Z there cannot reach
// the register.
module program_counter #(
  parameter int                  PC_SIZE      = 32,
  parameter logic [PC_SIZE-1:0]  RESET_VECTOR = '0
) (
  input  logic               clk,
  input  logic               arst,
  input  logic               en,
  input  logic [PC_SIZE-1:0] pc_in,
  output logic [PC_SIZE-1:0] pc_out,
  output logic               misaligned
);

  logic [PC_SIZE-1:0] r_pc;
  logic               r_misaligned;

  logic [PC_SIZE-1:0] w_pc_aligned;
  logic               w_pc_in_misaligned;

  // Word-align the requested address and detect a non-zero byte offset.
  always_comb begin
    w_pc_aligned       = {pc_in[PC_SIZE-1:2], 2'b00};
    w_pc_in_misaligned = (pc_in[1:0] != 2'b00);
  end

  // PC register: async reset wins over everything; hold on stall.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_pc <= RESET_VECTOR;
    end else if (en) begin
      r_pc <= w_pc_aligned;
    end
  end

  // Misaligned flag: pulses for exactly one cycle after an offending load,
  // cleared on any stall cycle so it never stretches.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_misaligned <= 1'b0;
    end else if (en) begin
      r_misaligned <= w_pc_in_misaligned;
    end else begin
      r_misaligned <= 1'b0;
    end
  end

  // Outputs come straight from the registers; no combinational path from pc_in.
  assign pc_out     = r_pc;
  assign misaligned = r_misaligned;

endmodule

// File: tb/tb_program_counter.sv
// tb_program_counter: directed plus randomized checks of program_counter
// against a behavioural model of the fetch PC.
module tb_program_counter;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic         clk;
  logic         arst;
  logic         en;
  logic [W-1:0] pc_in;
  logic [W-1:0] pc_out;
  logic         misaligned;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  program_counter #(
    .PC_SIZE      (W),
    .RESET_VECTOR ('0)
  ) dut (
    .clk        (clk),
    .arst       (arst),
    .en         (en),
    .pc_in      (pc_in),
    .pc_out     (pc_out),
    .misaligned (misaligned)
  );

  // ---------------- scoreboard ----------------
  int unsigned  errors = 0;
  int unsigned  checks = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_pc;    // model PC
  logic         m_mis;   // model misaligned flag

  task automatic chk_pc(input string tag, input logic [W-1:0] exp_v);
    checks++;
    assert (pc_out === exp_v) else begin
      errors++;
      $error("FAIL %s pc_out observed=%h expected=%h", tag, pc_out, exp_v);
    end
  endtask

  task automatic chk_mis(input string tag, input logic exp_v);
    checks++;
    assert (misaligned === exp_v) else begin
      errors++;
      $error("FAIL %s misaligned observed=%b expected=%b", tag, misaligned, exp_v);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called #1 after a rising edge: apply inputs, update the model, cross one
  // edge, then compare.
  task automatic cycle(input string tag, input logic e, input logic [W-1:0] p);
    en    = e;
    pc_in = p;
    if (e) begin
      m_pc  = p - (p % 4);
      m_mis = (p % 4) != 0;
    end else begin
      m_mis = 1'b0;
    end
    exp_q.push_back(m_pc);
    @(posedge clk);
    #1;
    chk_pc(tag, exp_q.pop_front());
    chk_mis(tag, m_mis);
  endtask

  // Assert reset between edges, check it takes effect before the next edge,
  // hold it across one edge with en=1, then release.
  task automatic mid_reset(input string tag);
    #3;
    arst = 1'b1;
    m_pc  = '0;
    m_mis = 1'b0;
    #1;
    chk_pc(tag, m_pc);
    chk_mis(tag, m_mis);
    en    = 1'b1;
    pc_in = $urandom;
    @(posedge clk);
    #1;
    chk_pc(tag, m_pc);
    chk_mis(tag, m_mis);
    arst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    arst  = 1'b1;
    en    = 1'b1;
    pc_in = 32'h0000_1234;
    m_pc  = '0;
    m_mis = 1'b0;

    // Reset held across several edges with en=1 and a live pc_in.
    #1;
    chk_pc("reset_t0", 32'h0);
    chk_mis("reset_t0", 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_pc("reset_held", 32'h0);
      chk_mis("reset_held", 1'b0);
    end

    // Release: PC must stay at the reset vector until the next edge.
    arst  = 1'b0;
    pc_in = 32'h0000_0004;
    @(negedge clk);
    chk_pc("release_hold", 32'h0);
    @(posedge clk);
    #1;
    m_pc = 32'h4;
    chk_pc("release_first_load", 32'h4);

    // Sequential fetch.
    for (int i = 0; i < 4; i++) cycle("seq", 1'b1, m_pc + 4);

    // Branch redirect then sequential.
    cycle("branch", 1'b1, 32'h0000_0100);
    cycle("branch_seq", 1'b1, m_pc + 4);

    // Stall at 0x10, including X on pc_in while stalled.
    cycle("to_0x10", 1'b1, 32'h0000_0010);
    cycle("stall", 1'b0, 32'h0000_0014);
    cycle("stall_x", 1'b0, 'x);
    cycle("stall", 1'b0, 32'h0000_0014);
    cycle("unstall", 1'b1, 32'h0000_0014);

    // Misalignment pulse, then an aligned load clears it.
    cycle("misal", 1'b1, 32'h0000_0022);
    cycle("misal_clear", 1'b1, 32'h0000_0024);
    // Misaligned load followed by a stall: flag still lasts one cycle.
    cycle("misal3", 1'b1, 32'h0000_0033);
    cycle("misal_stall", 1'b0, 32'h0000_0040);

    // Asynchronous reset mid-run at 0x40 with the flag set.
    cycle("to_0x40", 1'b1, 32'h0000_0041);
    mid_reset("async_reset");

    // Wrap-around with no error flag.
    cycle("wrap_top", 1'b1, 32'hFFFF_FFFC);
    cycle("wrap_zero", 1'b1, m_pc + 4);

    // Randomized traffic with occasional mid-cycle resets.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        mid_reset("rand_reset");
      end else begin
        cycle("rand", ($urandom_range(0, 3) != 0), $urandom);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/program_counter.md
Name: program_counter

Overview:
- Architectural program-counter register for the instruction-fetch stage of the RV32 pipeline.
- Holds the current fetch address and loads the next-PC value (sequential PC+4 or branch target, selected upstream) on every enabled clock edge.
- Supports a load-enable for stalls and a configurable reset vector.
- Flags misaligned next-PC requests.

Parameters:
- PC_SIZE, 32, width in bits of the PC and of pc_in/pc_out.
- RESET_VECTOR, 0 (PC_SIZE bits, all zeros), address loaded on reset; must be word-aligned (bits [1:0] = 0).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- arst  input  1  asynchronous, active-high reset.
- en  input  1  load enable; 1 = load pc_in at clock edge, 0 = hold (stall).
- pc_in  input  PC_SIZE  next-PC value computed by the fetch stage (PC+4 or branch target).
- pc_out  output  PC_SIZE  current PC, driven directly from the register (no combinational path from pc_in).
- misaligned  output  1  registered flag; 1 for the cycle after a load whose pc_in[1:0] was non-zero.

Behaviour:
- Reset:
  - arst=1 forces pc_out=RESET_VECTOR and misaligned=0 immediately, with no wait for clk.
  - Both are held while arst=1.
  - Release is synchronous in effect: the first load occurs at the first rising clk edge after arst deasserts.
- Load, rising edge, arst=0, en=1:
  - pc_out <= {pc_in[PC_SIZE-1:2], 2'b00}; the low two bits are always forced to 0, so pc_out stays word-aligned.
  - misaligned <= (pc_in[1:0] != 2'b00).
- Hold, rising edge, arst=0, en=0:
  - pc_out keeps its value.
  - misaligned <= 0, so the flag is a single-cycle pulse per offending load.
- Latency:
  - pc_in to pc_out is exactly one clock when en=1.
  - pc_out is stable for the whole cycle and is used as the combinational instruction-memory address.
- Wrap-around: a pc_in of 32'hFFFF_FFFC loads normally. The upstream PC+4 wraps to 0; the PC register applies no saturation or special casing.
- Reset mid-operation:
  - arst asserted at any point, including mid-cycle or coincident with a clock edge, wins over en and pc_in.
  - pc_out=RESET_VECTOR within the same cycle.
- No X propagation from reset: pc_out and misaligned are defined at all times once arst has been asserted at least once.
- pc_in values of X/Z while en=0 have no effect on state.

Test Plan:
- Reset: assert arst=1 with pc_in=32'h0000_1234, en=1, toggle clk -> pc_out=0, misaligned=0 throughout. Deassert arst -> pc_out still 0 until the next edge.
- Sequential fetch: from reset, drive pc_in=pc_out+4 with en=1 for 5 cycles -> pc_out sequence 0,4,8,12,16,20, misaligned always 0.
- Branch redirect: at pc_out=8, drive pc_in=32'h0000_0100 for one cycle -> next pc_out=0x100. Then pc_in=pc_out+4 -> 0x104.
- Stall: at pc_out=0x10, set en=0 for 3 cycles with pc_in=0x14 -> pc_out stays 0x10. Set en=1 -> 0x14 on the following edge.
- Misalignment: load pc_in=32'h0000_0022 -> pc_out=0x20 and misaligned=1 for exactly one cycle. Next load of 0x24 -> misaligned=0.
- Asynchronous reset mid-run: at pc_out=0x40, assert arst between clock edges -> pc_out=0 before the next edge. Also load 32'hFFFF_FFFC then 0 -> wrap with no error flag.
